// File: rtl/bv_cfg_ctrl.sv
// Rule-update controller for a bit-vector classifier: read-modify-writes one rule bit across every BV SRAM of a mode region.
// Optional write-back verification is enabled by defining BV_CFG_WRITE_VERIFY_EN.
module bv_cfg_ctrl #(
    parameter int STRIDE       = 4,
    parameter int MODE_WIDTH   = 2,
    parameter int RESULT_WIDTH = 32,
    parameter int SRAM_NUM     = 32
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 cmd_val,
    output logic                                 cmd_rdy,
    input  logic                                 cmd_op,
    input  logic [MODE_WIDTH-1:0]                cmd_mode,
    input  logic [$clog2(RESULT_WIDTH)-1:0]      cmd_bit,
    input  logic [STRIDE*SRAM_NUM-1:0]           cmd_value,
    input  logic [STRIDE*SRAM_NUM-1:0]           cmd_mask,
    input  logic                                 lkp_val,
    output logic [STRIDE+MODE_WIDTH-1:0]         ram_addr,
    output logic [SRAM_NUM-1:0]                  ram_wr_en,
    output logic [RESULT_WIDTH*SRAM_NUM-1:0]     ram_wdata,
    input  logic [RESULT_WIDTH*SRAM_NUM-1:0]     ram_rdata,
    output logic                                 cfg_busy,
    output logic                                 rsp_val,
    output logic                                 rsp_err
);

    localparam int BIT_W = $clog2(RESULT_WIDTH);
    localparam int KEY_W = STRIDE * SRAM_NUM;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_DONE
`ifdef BV_CFG_WRITE_VERIFY_EN
        ,
        S_VRD,
        S_VCHK
`endif
    } state_t;

    state_t             state_q, state_d;
    logic [STRIDE-1:0]  a_q, a_d;
    logic               op_q, op_d;
    logic [MODE_WIDTH-1:0] mode_q, mode_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [KEY_W-1:0]   value_q, value_d;
    logic [KEY_W-1:0]   mask_q, mask_d;
    logic [SRAM_NUM-1:0] wr_en_c;
    logic               rsp_val_c;
    logic [RESULT_WIDTH-1:0] word;

`ifdef BV_CFG_WRITE_VERIFY_EN
    logic [RESULT_WIDTH*SRAM_NUM-1:0] wdata_q, wdata_d;
    logic err_q, err_d;
`endif

    // The lookup side has absolute priority on the shared port; any cycle it
    // claims is a cycle this controller neither reads nor writes.
    assign ram_addr  = {mode_q, a_q};
    assign ram_wr_en = rst ? '0 : wr_en_c;
    assign rsp_val   = rsp_val_c & ~rst;
`ifdef BV_CFG_WRITE_VERIFY_EN
    assign rsp_err   = rsp_val & err_q;
`else
    assign rsp_err   = 1'b0;
`endif

    // Each SRAM i gets bit k set when address a matches its ternary slice.
    always_comb begin
        word      = '0;
        ram_wdata = '0;
        for (int i = 0; i < SRAM_NUM; i++) begin
            word         = ram_rdata[i*RESULT_WIDTH +: RESULT_WIDTH];
            word[bit_q]  = ~op_q &
                           (((a_q ^ value_q[i*STRIDE +: STRIDE]) & mask_q[i*STRIDE +: STRIDE]) == '0);
            ram_wdata[i*RESULT_WIDTH +: RESULT_WIDTH] = word;
        end
    end

    // cmd handshake: a command transfers on a cycle with cmd_val & cmd_rdy;
    // rsp_val is a single-cycle pulse with no backpressure.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        op_d      = op_q;
        mode_d    = mode_q;
        bit_d     = bit_q;
        value_d   = value_q;
        mask_d    = mask_q;
        cmd_rdy   = 1'b0;
        cfg_busy  = 1'b0;
        wr_en_c   = '0;
        rsp_val_c = 1'b0;
`ifdef BV_CFG_WRITE_VERIFY_EN
        wdata_d   = wdata_q;
        err_d     = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                cmd_rdy = 1'b1;
                if (cmd_val) begin
                    op_d    = cmd_op;
                    mode_d  = cmd_mode;
                    bit_d   = cmd_bit;
                    value_d = cmd_value;
                    mask_d  = cmd_mask;
                    a_d     = '0;
                    state_d = S_RD;
`ifdef BV_CFG_WRITE_VERIFY_EN
                    err_d   = 1'b0;
`endif
                end
            end
            S_RD: begin
                if (!lkp_val) begin
                    cfg_busy = 1'b1;
                    state_d  = S_WR;
                end
            end
            S_WR: begin
                if (lkp_val) begin
                    state_d = S_RD;
                end else begin
                    cfg_busy = 1'b1;
                    wr_en_c  = '1;
`ifdef BV_CFG_WRITE_VERIFY_EN
                    wdata_d  = ram_wdata;
                    state_d  = S_VRD;
`else
                    if (&a_q) begin
                        state_d = S_DONE;
                    end else begin
                        a_d     = a_q + 1'b1;
                        state_d = S_RD;
                    end
`endif
                end
            end
`ifdef BV_CFG_WRITE_VERIFY_EN
            S_VRD: begin
                if (!lkp_val) begin
                    cfg_busy = 1'b1;
                    state_d  = S_VCHK;
                end
            end
            S_VCHK: begin
                // Read data was captured last cycle, so lookup activity now is harmless.
                if (ram_rdata != wdata_q) err_d = 1'b1;
                if (&a_q) begin
                    state_d = S_DONE;
                end else begin
                    a_d     = a_q + 1'b1;
                    state_d = S_RD;
                end
            end
`endif
            S_DONE: begin
                rsp_val_c = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
`ifdef BV_CFG_WRITE_VERIFY_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
`ifdef BV_CFG_WRITE_VERIFY_EN
            err_q   <= err_d;
`endif
        end
    end

    // Command fields are only consumed outside IDLE, so they need no reset.
    always_ff @(posedge clk) begin
        op_q    <= op_d;
        mode_q  <= mode_d;
        bit_q   <= bit_d;
        value_q <= value_d;
        mask_q  <= mask_d;
`ifdef BV_CFG_WRITE_VERIFY_EN
        wdata_q <= wdata_d;
`endif
    end

endmodule
